// File: rtl/montgomery_result_buffer.sv
// Result buffer behind the Montgomery reducer. It hands out issue credits so that
// in-flight work plus buffered results never exceed DEPTH, then drains FIFO-style.
module montgomery_result_buffer #(
   parameter  int DEPTH  = 16,
   parameter  int DATA_W = 64,
   localparam int CW     = $clog2(DEPTH + 1),
   localparam int PW     = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              issue_i,
   output logic              can_issue_o,
   input  logic              res_valid_i,
   input  logic [DATA_W-1:0] res_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CW-1:0]     count_o,
   output logic [CW-1:0]     inflight_o,
   output logic [2:0]        err_o
);

   localparam logic [CW:0]   DEPTH_X = (CW + 1)'(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     rptr;
   logic [PW-1:0]     wptr;
   logic [CW-1:0]     count;
   logic [CW-1:0]     inflight;
   logic [2:0]        err;

   logic can_issue;
   logic full;
   logic push;
   logic pop;
   logic infl_zero;
   logic infl_sat;
   logic infl_inc;
   logic infl_dec;

   always_comb begin
      can_issue = ({1'b0, inflight} + {1'b0, count}) < DEPTH_X;
      full      = (count == DEPTH_C);
      pop       = (count != '0) && out_ready_i;
      // A full FIFO still accepts a result when the head leaves in the same cycle.
      push      = res_valid_i && (!full || pop);
      infl_zero = (inflight == '0);
      infl_sat  = (inflight == DEPTH_C);
      infl_inc  = issue_i && !infl_sat;
      infl_dec  = res_valid_i && !infl_zero;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rptr     <= '0;
         wptr     <= '0;
         count    <= '0;
         inflight <= '0;
         err      <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);

         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);

         if (infl_inc && !infl_dec)      inflight <= inflight + CW'(1);
         else if (infl_dec && !infl_inc) inflight <= inflight - CW'(1);

         err <= err | {res_valid_i && !push,
                       res_valid_i && infl_zero,
                       issue_i && !can_issue};
      end
   end

   // Storage carries no reset; its contents are only visible while count != 0.
   always_ff @(posedge clk_i) begin
      if (push) mem[wptr] <= res_data_i;
   end

   assign can_issue_o = can_issue;
   assign out_valid_o = (count != '0);
   assign out_data_o  = (count != '0) ? mem[rptr] : '0;
   assign count_o     = count;
   assign inflight_o  = inflight;
   assign err_o       = err;

endmodule

// File: tb/tb_montgomery_result_buffer.sv
// Directed bench for montgomery_result_buffer: a DEPTH=4 instance for credit, FIFO
// and error behaviour, and a DEPTH=32 instance for long-latency streaming.
module tb_montgomery_result_buffer;

   logic        clk_i = 1'b0;
   logic        rst_ni;

   logic        issue, res_valid, out_ready;
   logic [63:0] res_data;
   logic        can_issue, out_valid;
   logic [63:0] out_data;
   logic [2:0]  count, inflight, err;

   logic        s_issue, s_res_valid, s_out_ready;
   logic [63:0] s_res_data;
   logic        s_can_issue, s_out_valid;
   logic [63:0] s_out_data;
   logic [5:0]  s_count, s_inflight;
   logic [2:0]  s_err;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   montgomery_result_buffer #(.DEPTH(4), .DATA_W(64)) u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .issue_i(issue), .can_issue_o(can_issue),
      .res_valid_i(res_valid), .res_data_i(res_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .count_o(count), .inflight_o(inflight), .err_o(err)
   );

   montgomery_result_buffer #(.DEPTH(32), .DATA_W(64)) u_dut_stream (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .issue_i(s_issue), .can_issue_o(s_can_issue),
      .res_valid_i(s_res_valid), .res_data_i(s_res_data),
      .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .out_data_o(s_out_data),
      .count_o(s_count), .inflight_o(s_inflight), .err_o(s_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_ni    = 1'b0;
      issue     = 1'b0;
      res_valid = 1'b0;
      out_ready = 1'b0;
      res_data  = '0;
      repeat (2) tick();
      rst_ni = 1'b1;
   endtask

   task automatic do_issue(input int n);
      issue = 1'b1;
      repeat (n) tick();
      issue = 1'b0;
   endtask

   task automatic do_return(input logic [63:0] v);
      res_valid = 1'b1;
      res_data  = v;
      tick();
      res_valid = 1'b0;
      res_data  = '0;
   endtask

   task automatic drain(input string tag, input logic [63:0] e0, input logic [63:0] e1,
                        input logic [63:0] e2, input logic [63:0] e3);
      logic [63:0] exp [4];
      exp = '{e0, e1, e2, e3};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check({tag, "_valid"}, 64'(out_valid), 64'd1);
         check({tag, "_head"}, out_data, exp[i]);
         tick();
      end
      out_ready = 1'b0;
      check({tag, "_empty"}, 64'(count), 64'd0);
   endtask

   initial begin
      s_issue = 1'b0; s_res_valid = 1'b0; s_out_ready = 1'b0; s_res_data = '0;
      do_reset();

      // Reset then idle
      tick();
      check("rst_can_issue", 64'(can_issue), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_inflight", 64'(inflight), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_out_data", out_data, 64'd0);

      // Four issues exhaust the credit pool
      issue = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("issue_inflight", 64'(inflight), 64'(i));
      end
      issue = 1'b0;
      check("issue_no_credit", 64'(can_issue), 64'd0);

      do_return(64'h11);
      check("ret1_valid", 64'(out_valid), 64'd1);
      check("ret1_head", out_data, 64'h11);
      do_return(64'h22);
      do_return(64'h33);
      do_return(64'h44);
      check("ret_count", 64'(count), 64'd4);
      check("ret_inflight", 64'(inflight), 64'd0);
      check("ret_no_credit", 64'(can_issue), 64'd0);

      out_ready = 1'b1;
      check("pop_head0", out_data, 64'h11);
      tick();
      check("pop_credit_back", 64'(can_issue), 64'd1);
      check("pop_head1", out_data, 64'h22);
      tick();
      check("pop_head2", out_data, 64'h33);
      tick();
      check("pop_head3", out_data, 64'h44);
      tick();
      out_ready = 1'b0;
      check("pop_empty_valid", 64'(out_valid), 64'd0);
      check("pop_empty_count", 64'(count), 64'd0);
      check("pop_err", 64'(err), 64'd0);

      // Streaming on the deep instance: issue each cycle, results return 21 cycles later
      s_out_ready = 1'b1;
      for (int t = 0; t < 75; t++) begin
         s_issue     = (t < 50);
         s_res_valid = (t >= 21 && t < 71);
         s_res_data  = (t >= 21 && t < 71) ? 64'(t - 20) : 64'd0;
         if (t < 50) check("stream_credit", 64'(s_can_issue), 64'd1);
         tick();
         if (t >= 21 && t < 71) begin
            check("stream_valid", 64'(s_out_valid), 64'd1);
            check("stream_data", s_out_data, 64'(t - 20));
         end
         check("stream_count_le1", 64'(s_count <= 6'd1), 64'd1);
      end
      s_issue = 1'b0; s_res_valid = 1'b0; s_out_ready = 1'b0;
      check("stream_err", 64'(s_err), 64'd0);
      check("stream_final_count", 64'(s_count), 64'd0);
      check("stream_final_inflight", 64'(s_inflight), 64'd0);

      // Backpressure on a full FIFO with a same-cycle return
      do_issue(4);
      do_return(64'hB1);
      do_return(64'hB2);
      do_return(64'hB3);
      do_issue(1);
      check("bp_extra_issue_err", 64'(err), 64'b001);
      check("bp_extra_inflight", 64'(inflight), 64'd2);
      do_return(64'hB4);
      check("bp_full_count", 64'(count), 64'd4);
      out_ready = 1'b1;
      res_valid = 1'b1;
      res_data  = 64'hB5;
      tick();
      res_valid = 1'b0;
      out_ready = 1'b0;
      check("bp_overlap_count", 64'(count), 64'd4);
      check("bp_overlap_inflight", 64'(inflight), 64'd0);
      check("bp_no_drop", 64'(err[2]), 64'd0);
      check("bp_hold0", out_data, 64'hB2);
      tick();
      check("bp_hold1", out_data, 64'hB2);
      tick();
      check("bp_hold2", out_data, 64'hB2);
      check("bp_hold_count", 64'(count), 64'd4);
      drain("bp_drain", 64'hB2, 64'hB3, 64'hB4, 64'hB5);

      do_reset();
      check("rst2_err", 64'(err), 64'd0);

      // Protocol errors
      do_issue(4);
      do_issue(1);
      check("perr_issue_err", 64'(err), 64'b001);
      check("perr_issue_sat", 64'(inflight), 64'd4);
      do_return(64'hC1);
      do_return(64'hC2);
      do_return(64'hC3);
      do_return(64'hC4);
      check("perr_full_count", 64'(count), 64'd4);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("perr_pop_count", 64'(count), 64'd3);
      do_return(64'hD0);
      check("perr_orphan_err", 64'(err), 64'b011);
      check("perr_orphan_pushed", 64'(count), 64'd4);
      do_return(64'hE0);
      check("perr_drop_err", 64'(err), 64'b111);
      check("perr_drop_count", 64'(count), 64'd4);
      drain("perr_drain", 64'hC2, 64'hC3, 64'hC4, 64'hD0);

      // Reset in the middle of operation
      do_reset();
      do_issue(4);
      do_return(64'h71);
      do_return(64'h72);
      do_return(64'h73);
      check("mid_count", 64'(count), 64'd3);
      check("mid_inflight", 64'(inflight), 64'd1);
      rst_ni = 1'b0;
      #1;
      check("mid_async_count", 64'(count), 64'd0);
      check("mid_async_inflight", 64'(inflight), 64'd0);
      check("mid_async_valid", 64'(out_valid), 64'd0);
      check("mid_async_credit", 64'(can_issue), 64'd1);
      check("mid_async_data", out_data, 64'd0);
      #2;
      rst_ni = 1'b1;
      do_return(64'hF0);
      check("mid_late_err", 64'(err), 64'b010);
      check("mid_late_count", 64'(count), 64'd1);
      check("mid_late_head", out_data, 64'hF0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
